shift_ctrl: RTL and testbench



---
 rtl/shift_ctrl_pkg.sv | 41 ++++
 rtl/shift_ctrl_if.sv | 24 ++
 rtl/shift_ctrl_step.sv | 34 +++
 rtl/shift_ctrl.sv | 96 +++++++++
 tb/tb_shift_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the multi-cycle shift controller.
// Optional feature macro: SHIFT_CTRL_COARSE16_EN adds a 16-bit step state (C16).
package shift_ctrl_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        STEP1  = 2'd0,
        STEP4  = 2'd1,
        STEP16 = 2'd2
    } step_t;

    typedef enum logic [2:0] {
        IDLE,
`ifdef SHIFT_CTRL_COARSE16_EN
        C16,
`endif
        COARSE,
        FINE,
        DONE
    } state_t;

    // Largest step that still fits in the remaining amount; DONE once nothing is left.
    function automatic state_t pick_state(input logic [SHAMT_W-1:0] r);
`ifdef SHIFT_CTRL_COARSE16_EN
        if (r >= SHAMT_W'(16)) return C16;
`endif
        if (r >= SHAMT_W'(4)) return COARSE;
        if (r != '0) return FINE;
        return DONE;
    endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Request/response bundle between the main control FSM and the shift controller.
interface shift_ctrl_if;
    import shift_ctrl_pkg::*;

    logic               start_i;
    logic [1:0]         op_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   data_i;
    logic               flush_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   result_o;

    modport master (
        output start_i, op_i, shamt_i, data_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, shamt_i, data_i, flush_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/shift_ctrl_step.sv
// Fixed-step shifter: one shift of 1, 4 or 16 positions for SLL/SRL/SRA.
// Each step size is a constant shift, so no general barrel shifter is built.
module shift_step
    import shift_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    input  step_t            step,
    output logic [WIDTH-1:0] shifted
);

    function automatic logic [WIDTH-1:0] shift_const(input logic [WIDTH-1:0] a,
                                                     input logic [1:0] o,
                                                     input int n);
        case (o)
            OP_SLL:  return a << n;
            OP_SRL:  return a >> n;
            OP_SRA:  return $signed(a) >>> n;
            default: return a;
        endcase
    endfunction

    // Select the constant-distance shift for the requested step size.
    always_comb begin
        shifted = acc;
        case (step)
            STEP1:   shifted = shift_const(acc, op, 1);
            STEP4:   shifted = shift_const(acc, op, 4);
            STEP16:  shifted = shift_const(acc, op, 16);
            default: shifted = acc;
        endcase
    end

endmodule

// File: rtl/shift_ctrl.sv
// Multi-cycle shift controller: iterates shift_step to execute SLL/SRL/SRA.
// Optional feature macro: SHIFT_CTRL_COARSE16_EN (adds C16 state, shorter latency).
module shift_ctrl
    import shift_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    shift_ctrl_if.slave  bus
);

    state_t             state, next_state;
    logic [WIDTH-1:0]   acc, acc_d, res_q, step_out;
    logic [SHAMT_W-1:0] rem, rem_d;
    logic [1:0]         op_q, op_d;
    step_t              step_sel;

    shift_step u_step (
        .acc     (acc),
        .op      (op_q),
        .step    (step_sel),
        .shifted (step_out)
    );

    // Next-state and datapath update; flush overrides everything including a new start.
    always_comb begin
        next_state = state;
        acc_d      = acc;
        rem_d      = rem;
        op_d       = op_q;
        step_sel   = STEP1;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    acc_d      = bus.data_i;
                    op_d       = bus.op_i;
                    rem_d      = (bus.op_i == OP_RSV) ? '0 : bus.shamt_i;
                    next_state = pick_state(rem_d);
                end
            end
`ifdef SHIFT_CTRL_COARSE16_EN
            C16: begin
                step_sel   = STEP16;
                acc_d      = step_out;
                rem_d      = rem - SHAMT_W'(16);
                next_state = pick_state(rem_d);
            end
`endif
            COARSE: begin
                step_sel   = STEP4;
                acc_d      = step_out;
                rem_d      = rem - SHAMT_W'(4);
                next_state = pick_state(rem_d);
            end
            FINE: begin
                step_sel   = STEP1;
                acc_d      = step_out;
                rem_d      = rem - SHAMT_W'(1);
                next_state = pick_state(rem_d);
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (bus.flush_i) begin
            next_state = IDLE;
            acc_d      = acc;
            rem_d      = rem;
            op_d       = op_q;
        end
    end

    // State and datapath registers; the result is latched as the FSM enters DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            op_q  <= OP_SLL;
            res_q <= '0;
        end else begin
            state <= next_state;
            acc   <= acc_d;
            rem   <= rem_d;
            op_q  <= op_d;
            if (next_state == DONE) res_q <= acc_d;
        end
    end

    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = (state == DONE);
    assign bus.result_o = res_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed self-checking bench for shift_ctrl (also valid with SHIFT_CTRL_COARSE16_EN).
module tb_shift_ctrl;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    shift_ctrl_if bus();

    shift_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input int s,
                                             input logic [31:0] d);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return d;
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input int s);
        if (op == 2'b11) return 1;
`ifdef SHIFT_CTRL_COARSE16_EN
        return 1 + s / 16 + (s % 16) / 4 + s % 4;
`else
        return 1 + s / 4 + s % 4;
`endif
    endfunction

    // Issue one op, wait (bounded) for done_o, check latency/result and busy fall.
    task automatic apply_stimulus(input string tag, input logic [1:0] op, input int s,
                                  input logic [31:0] data, input logic [31:0] exp_res,
                                  input int exp_lat);
        int lat;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.shamt_i = 5'(s);
        bus.data_i  = data;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat = 1;
        while (!bus.done_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output({tag, "_done"}, 32'(bus.done_o), 32'd1);
        check_output({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "_res"}, bus.result_o, exp_res);
        @(posedge clk);
        #1;
        check_output({tag, "_busyfall"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int dones;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.shamt_i = '0;
        bus.data_i  = '0;
        bus.flush_i = 1'b0;

        // Reset state
        #12;
        check_output("rst_busy", 32'(bus.busy_o), 32'd0);
        check_output("rst_done", 32'(bus.done_o), 32'd0);
        check_output("rst_res", bus.result_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors from hand-computed values
        apply_stimulus("sll_s2", 2'b00, 2, 32'h0000_0001, 32'h0000_0004, exp_latency(2'b00, 2));
        apply_stimulus("sll_s31", 2'b00, 31, 32'h0000_0001, 32'h8000_0000, exp_latency(2'b00, 31));
        apply_stimulus("sra_s4", 2'b10, 4, 32'h8000_0010, 32'hF800_0001, 2);
        apply_stimulus("srl_s4", 2'b01, 4, 32'h8000_0010, 32'h0800_0001, 2);
        apply_stimulus("s0", 2'b00, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        apply_stimulus("rsv_s7", 2'b11, 7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        apply_stimulus("srl_ones_s31", 2'b01, 31, 32'hFFFF_FFFF, 32'h0000_0001, exp_latency(2'b01, 31));
        apply_stimulus("sra_neg_s31", 2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF, exp_latency(2'b10, 31));
        apply_stimulus("sra_pos_s17", 2'b10, 17, 32'h7000_0000, 32'h0000_3800, exp_latency(2'b10, 17));

        // start_i held high through an s=5 op: one done, re-accept only from IDLE
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.shamt_i = 5'd5;
        bus.data_i  = 32'h0000_0003;
        @(posedge clk);
        #1;
        check_output("hold_busy_rise", 32'(bus.busy_o), 32'd1);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        check_output("hold_one_done", 32'(dones), 32'd1);
        check_output("hold_idle", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        check_output("hold_reaccept", 32'(bus.busy_o), 32'd1);
        bus.start_i = 1'b0;
        dones = 0;
        for (int i = 0; i < 20 && dones == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        check_output("hold_second_done", 32'(dones), 32'd1);
        check_output("hold_second_res", bus.result_o, 32'h0000_0060);
        @(posedge clk);
        #1;

        // flush_i while in FINE: back to IDLE, no done, result unchanged
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.shamt_i = 5'd6;
        bus.data_i  = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check_output("flush_busy", 32'(bus.busy_o), 32'd0);
        check_output("flush_done", 32'(bus.done_o), 32'd0);
        check_output("flush_res", bus.result_o, 32'h0000_0060);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        check_output("flush_no_done", 32'(dones), 32'd0);

        // Sweep every shift amount with random op and data against the reference shift
        for (int s = 0; s < 32; s++) begin
            logic [1:0]  rop;
            logic [31:0] rdata;
            rop   = 2'($urandom_range(0, 3));
            rdata = $urandom;
            apply_stimulus($sformatf("sweep_op%0d_s%0d", rop, s), rop, s, rdata,
                           ref_shift(rop, (rop == 2'b11) ? 0 : s, rdata), exp_latency(rop, s));
        end

        // Asynchronous reset mid-operation at s=31
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.shamt_i = 5'd31;
        bus.data_i  = 32'h0000_0001;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("arst_busy", 32'(bus.busy_o), 32'd0);
        check_output("arst_done", 32'(bus.done_o), 32'd0);
        check_output("arst_res", bus.result_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        check_output("arst_no_done", 32'(dones), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
